// File: rtl/gemm_pkg.sv
// Shared types for the GEMM custom-instruction responder: op encoding,
// queued command payload, dispatch FSM states and the default opcode.
package gemm_pkg;

  localparam logic [6:0] GEMM_OPC = 7'b0001011;

  typedef enum logic [2:0] {
    CONFIG  = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    STORE_C = 3'd4,
    FENCE   = 3'd5
  } gemm_op_e;

  typedef struct packed {
    gemm_op_e    op;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } gemm_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ENG
  } disp_state_e;

endpackage

// File: rtl/rocc_gemm_responder_if.sv
// Core command handshake plus engine start/done bus. master = core/engine
// environment side, slave = the responder.
interface rocc_gemm_responder_if;
  logic        cmd_valid;
  logic [31:0] cmd_instr;
  logic [31:0] cmd_rs1;
  logic [31:0] cmd_rs2;
  logic        cmd_ready;
  logic        done;
  logic        cmd_err;
  logic        eng_start;
  logic [2:0]  eng_op;
  logic [31:0] eng_addr;
  logic [31:0] eng_arg;
  logic [31:0] eng_cfg_dim;
  logic [31:0] eng_cfg_stride;
  logic        eng_done;

  modport master (
    output cmd_valid, cmd_instr, cmd_rs1, cmd_rs2, eng_done,
    input  cmd_ready, done, cmd_err, eng_start, eng_op, eng_addr, eng_arg,
           eng_cfg_dim, eng_cfg_stride
  );

  modport slave (
    input  cmd_valid, cmd_instr, cmd_rs1, cmd_rs2, eng_done,
    output cmd_ready, done, cmd_err, eng_start, eng_op, eng_addr, eng_arg,
           eng_cfg_dim, eng_cfg_stride
  );
endinterface

// File: rtl/gemm_cmd_fifo.sv
// In-order command queue; pointers carry one extra wrap bit so full/empty
// fall out of a plain compare.
module gemm_cmd_fifo
  import gemm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  gemm_cmd_t din,
  input  logic      pop,
  output gemm_cmd_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  gemm_cmd_t   mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/rocc_gemm_responder.sv
// Accelerator end of the GEMM custom-0 handshake: decode, queue, dispatch.
// Optional perf counters under GEMM_PERF_CNT_EN.
module rocc_gemm_responder
  import gemm_pkg::*;
#(
  parameter int         QDEPTH     = 4,
  parameter logic [6:0] CUSTOM_OPC = GEMM_OPC
) (
  input  logic                 clk,
  input  logic                 rst,
  rocc_gemm_responder_if.slave bus,
  output logic [31:0]          perf_busy,
  output logic [31:0]          perf_ops
);
  logic [6:0]  funct7, opcode;
  logic        legal, is_fence, accept, push, pop, full, empty;
  logic        pending, fence_wait, live, fence_fire;
  logic        load_eng, load_cfg;
  gemm_cmd_t   push_cmd, head;
  disp_state_e state, state_nxt;

  assign funct7   = bus.cmd_instr[31:25];
  assign opcode   = bus.cmd_instr[6:0];
  assign legal    = (opcode == CUSTOM_OPC) && (funct7 <= 7'd5);
  assign is_fence = legal && (funct7 == 7'd5);

  // live keeps cmd_ready low through reset and rises one cycle after release
  assign bus.cmd_ready = live & ~pending & ~fence_wait & ~full;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign push          = accept & legal & ~is_fence;
  assign push_cmd      = '{op: gemm_op_e'(funct7[2:0]), rs1: bus.cmd_rs1, rs2: bus.cmd_rs2};
  assign fence_fire    = (fence_wait | (accept & is_fence)) & empty & (state == S_IDLE);

  gemm_cmd_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live        <= 1'b0;
      pending     <= 1'b0;
      fence_wait  <= 1'b0;
      bus.done    <= 1'b0;
      bus.cmd_err <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept)        pending <= 1'b1;
      else if (bus.done) pending <= 1'b0;
      fence_wait  <= ~fence_fire & (fence_wait | (accept & is_fence));
      bus.done    <= (accept & ~is_fence) | fence_fire;
      bus.cmd_err <= bus.cmd_err | (accept & ~legal);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_eng  = 1'b0;
    load_cfg  = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        // CONFIG retires in place so it stays ordered against engine ops
        if (head.op == CONFIG) load_cfg = 1'b1;
        else begin
          load_eng  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:    state_nxt = S_WAIT_ENG;
      S_WAIT_ENG: if (bus.eng_done) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign bus.eng_start = (state == S_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.eng_op         <= '0;
      bus.eng_addr       <= '0;
      bus.eng_arg        <= '0;
      bus.eng_cfg_dim    <= '0;
      bus.eng_cfg_stride <= '0;
    end else begin
      if (load_eng) begin
        bus.eng_op   <= head.op;
        bus.eng_addr <= head.rs1;
        bus.eng_arg  <= head.rs2;
      end
      if (load_cfg) begin
        bus.eng_cfg_dim    <= head.rs1;
        bus.eng_cfg_stride <= head.rs2;
      end
    end
  end

`ifdef GEMM_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy <= '0;
      perf_ops  <= '0;
    end else begin
      if (state != S_IDLE) perf_busy <= perf_busy + 32'd1;
      if (bus.eng_start)   perf_ops  <= perf_ops + 32'd1;
    end
  end
`else
  assign perf_busy = '0;
  assign perf_ops  = '0;
`endif
endmodule

// File: tb/tb_rocc_gemm_responder.sv
// Self-checking bench: randomized core commands, an engine model with a
// scoreboard of expected dispatches, and latency/ordering/reset checks.
module tb_rocc_gemm_responder;
  import gemm_pkg::*;

  localparam logic [6:0] OPC = 7'b0001011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] perf_busy, perf_ops;

  rocc_gemm_responder_if bus ();

  rocc_gemm_responder #(.QDEPTH(4), .CUSTOM_OPC(OPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .perf_busy (perf_busy),
    .perf_ops  (perf_ops)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  // expected engine dispatch, with the config that must be in effect
  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1, rs2, dim, stride;
  } exp_t;

  exp_t        exp_q[$];
  int          rd_idx = 0;
  logic [31:0] m_dim = '0, m_stride = '0;

  bit auto_eng = 1'b1;
  int dly_min = 0, dly_max = 3;
  int rel_req = 0, rel_ack = 0;
  int m_starts = 0, m_dones = 0, m_busy = 0;
  int last_start_cyc = -1, last_done_cyc = -1;
  bit inflight = 1'b0;
  int wait_cnt = 0;

  // engine model + dispatch scoreboard
  initial begin
    exp_t e;
    bus.eng_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      if (rst) begin
        inflight = 1'b0;
        m_starts = 0;
        m_busy   = 0;
        rd_idx   = exp_q.size();
        rel_ack  = rel_req;
      end else if (bus.eng_start) begin
        n_checks++;
        if (rd_idx >= exp_q.size()) begin
          n_errs++;
          $display("FAIL eng_start_unexpected: got op=%0d addr=%h, expected no dispatch", bus.eng_op, bus.eng_addr);
        end else begin
          e = exp_q[rd_idx];
          rd_idx++;
          if (bus.eng_op !== e.op || bus.eng_addr !== e.rs1 || bus.eng_arg !== e.rs2 ||
              bus.eng_cfg_dim !== e.dim || bus.eng_cfg_stride !== e.stride) begin
            n_errs++;
            $display("FAIL eng_dispatch: got op=%0d addr=%h arg=%h dim=%h stride=%h, expected op=%0d addr=%h arg=%h dim=%h stride=%h",
                     bus.eng_op, bus.eng_addr, bus.eng_arg, bus.eng_cfg_dim, bus.eng_cfg_stride,
                     e.op, e.rs1, e.rs2, e.dim, e.stride);
          end
        end
        inflight       = 1'b1;
        m_starts++;
        m_busy++;
        last_start_cyc = cyc;
        wait_cnt       = $urandom_range(dly_max, dly_min);
      end else if (inflight) begin
        m_busy++;
        if (auto_eng ? (wait_cnt == 0) : (rel_req != rel_ack)) begin
          bus.eng_done  = 1'b1;
          last_done_cyc = cyc;
          m_dones++;
          inflight      = 1'b0;
          if (!auto_eng) rel_ack++;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
      end
    end
  end

  // Called and returns just after a negedge.
  task automatic send_cmd(input logic [6:0] f7, input logic [6:0] opc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input int exp_lat, input string name, output int dcyc);
    int n, acc;
    logic [31:0] r;
    bit lg;
    n = 0;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!bus.cmd_ready) begin
      n_errs++;
      $display("FAIL %s ready_timeout: cmd_ready=0 after %0d cycles, expected 1", name, n);
      dcyc = -1;
      return;
    end
    r = $urandom();
    bus.cmd_instr = {f7, r[24:7], opc};
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_valid = 1'b1;
    lg = (opc == OPC) && (f7 <= 7'd5);
    if (lg && f7 == 7'd0) begin
      m_dim    = rs1;
      m_stride = rs2;
    end else if (lg && f7 < 7'd5) begin
      exp_q.push_back('{op: f7[2:0], rs1: rs1, rs2: rs2, dim: m_dim, stride: m_stride});
    end
    acc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 300);
    dcyc = cyc;
    n_checks++;
    if (!bus.done) begin
      n_errs++;
      $display("FAIL %s done_timeout: done=0 after %0d cycles, expected a pulse", name, n);
    end else if (exp_lat > 0 && (dcyc - acc) != exp_lat) begin
      n_errs++;
      $display("FAIL %s done_latency: got %0d cycles, expected %0d", name, dcyc - acc, exp_lat);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin
      n_errs++;
      $display("FAIL %s ready_in_done_cycle: got %b, expected 0", name, bus.cmd_ready);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_errs++;
      $display("FAIL %s done_width: done=%b the cycle after the pulse, expected 0", name, bus.done);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((inflight || rd_idx != exp_q.size()) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (inflight || rd_idx != exp_q.size()) begin
      n_errs++;
      $display("FAIL idle_timeout: %0d dispatches outstanding, expected 0", exp_q.size() - rd_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin
      n_errs++;
      $display("FAIL reset_ready: got %b, expected 0", bus.cmd_ready);
    end
    n_checks++;
    if ({bus.done, bus.cmd_err, bus.eng_start, bus.eng_op, bus.eng_addr, bus.eng_arg,
         bus.eng_cfg_dim, bus.eng_cfg_stride, perf_busy, perf_ops} !== '0) begin
      n_errs++;
      $display("FAIL reset_outputs: done=%b err=%b start=%b op=%0d addr=%h arg=%h dim=%h stride=%h pb=%0d po=%0d, expected all 0",
               bus.done, bus.cmd_err, bus.eng_start, bus.eng_op, bus.eng_addr, bus.eng_arg,
               bus.eng_cfg_dim, bus.eng_cfg_stride, perf_busy, perf_ops);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_errs++;
      $display("FAIL reset_release_ready: got %b, expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_single();
    int dc;
    auto_eng = 1'b1;
    dly_min  = 2;
    dly_max  = 2;
    send_cmd(7'd1, OPC, 32'h1000, 32'h40, 1, "single", dc);
    // now at negedge of T2 (done was T1)
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.eng_start !== 1'b1) begin
      n_errs++;
      $display("FAIL single_t2: ready=%b start=%b, expected 1 1", bus.cmd_ready, bus.eng_start);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.eng_start !== 1'b0 || bus.eng_op !== 3'd1 || bus.eng_addr !== 32'h1000 || bus.eng_arg !== 32'h40) begin
        n_errs++;
        $display("FAIL single_hold: start=%b op=%0d addr=%h arg=%h, expected 0 1 00001000 00000040",
                 bus.eng_start, bus.eng_op, bus.eng_addr, bus.eng_arg);
      end
    end
    wait_idle();
  endtask

  task automatic test_random();
    int dc;
    auto_eng = 1'b1;
    dly_min  = 0;
    dly_max  = 4;
    for (int i = 0; i < 24; i++) begin
      send_cmd(7'($urandom_range(4, 0)), OPC, $urandom(), $urandom(), 1, "random", dc);
    end
    wait_idle();
  endtask

  task automatic test_queue_fill();
    int dc, n;
    bit stuck_low;
    auto_eng = 1'b0;
    send_cmd(7'd0, OPC, 32'h0008_0008, 32'h20, 1, "fill_config", dc);
    n_checks++;
    if (bus.eng_cfg_dim !== 32'h0008_0008 || bus.eng_cfg_stride !== 32'h20) begin
      n_errs++;
      $display("FAIL fill_config_regs: dim=%h stride=%h, expected 00080008 00000020", bus.eng_cfg_dim, bus.eng_cfg_stride);
    end
    for (int k = 1; k <= 4; k++) begin
      send_cmd(7'(k), OPC, $urandom(), $urandom(), 1, "fill_op", dc);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.eng_op !== 3'd1) begin
      n_errs++;
      $display("FAIL fill_three_queued: ready=%b eng_op=%0d, expected 1 1", bus.cmd_ready, bus.eng_op);
    end
    send_cmd(7'd3, OPC, $urandom(), $urandom(), 1, "fill_last", dc);
    stuck_low = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.cmd_ready !== 1'b0) stuck_low = 1'b0;
    end
    n_checks++;
    if (!stuck_low) begin
      n_errs++;
      $display("FAIL fill_full_ready: cmd_ready rose while full, expected 0");
    end
    rel_req++;
    n = 0;
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_errs++;
      $display("FAIL fill_ready_after_done: got %b, expected 1", bus.cmd_ready);
    end
    rel_req += 4;
    wait_idle();
    auto_eng = 1'b1;
  endtask

  task automatic test_fence();
    int dc, d0;
    auto_eng = 1'b1;
    dly_min  = 4;
    dly_max  = 4;
    d0 = m_dones;
    send_cmd(7'd1, OPC, $urandom(), $urandom(), 1, "fence_op1", dc);
    send_cmd(7'd2, OPC, $urandom(), $urandom(), 1, "fence_op2", dc);
    send_cmd(7'd5, OPC, $urandom(), $urandom(), 0, "fence_busy", dc);
    n_checks++;
    if (m_dones - d0 != 2 || dc != last_done_cyc + 2) begin
      n_errs++;
      $display("FAIL fence_busy_timing: done at cycle %0d after %0d engine dones, expected cycle %0d after 2",
               dc, m_dones - d0, last_done_cyc + 2);
    end
    wait_idle();
    send_cmd(7'd5, OPC, 32'h0, 32'h0, 1, "fence_idle", dc);
  endtask

  task automatic test_illegal();
    int dc, s0;
    wait_idle();
    s0 = m_starts;
    n_checks++;
    if (bus.cmd_err !== 1'b0) begin
      n_errs++;
      $display("FAIL illegal_err_clear: got %b, expected 0", bus.cmd_err);
    end
    send_cmd(7'd7, OPC, $urandom(), $urandom(), 1, "illegal_f7", dc);
    n_checks++;
    if (bus.cmd_err !== 1'b1) begin
      n_errs++;
      $display("FAIL illegal_err_set: got %b, expected 1", bus.cmd_err);
    end
    send_cmd(7'd1, 7'b0110011, $urandom(), $urandom(), 1, "illegal_opc", dc);
    send_cmd(7'($urandom_range(127, 6)), OPC, $urandom(), $urandom(), 1, "illegal_rand", dc);
    repeat (5) @(negedge clk);
    n_checks++;
    if (m_starts != s0) begin
      n_errs++;
      $display("FAIL illegal_no_start: %0d engine starts, expected 0", m_starts - s0);
    end
    send_cmd(7'd2, OPC, $urandom(), $urandom(), 1, "illegal_then_legal", dc);
    wait_idle();
    n_checks++;
    if (bus.cmd_err !== 1'b1) begin
      n_errs++;
      $display("FAIL illegal_err_sticky: got %b, expected 1", bus.cmd_err);
    end
  endtask

  task automatic test_perf();
    logic [31:0] e_busy, e_ops;
    wait_idle();
`ifdef GEMM_PERF_CNT_EN
    e_busy = 32'(m_busy);
    e_ops  = 32'(m_starts);
`else
    e_busy = '0;
    e_ops  = '0;
`endif
    n_checks++;
    if (perf_ops !== e_ops || perf_busy !== e_busy) begin
      n_errs++;
      $display("FAIL perf_counts: ops=%0d busy=%0d, expected ops=%0d busy=%0d", perf_ops, perf_busy, e_ops, e_busy);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    logic [31:0] a;
    auto_eng = 1'b0;
    a = $urandom() | 32'h1;
    send_cmd(7'd1, OPC, a, $urandom(), 1, "rmid_op1", dc);
    send_cmd(7'd3, OPC, $urandom(), $urandom(), 1, "rmid_op2", dc);
    n_checks++;
    if (bus.eng_op !== 3'd1 || bus.eng_addr !== a) begin
      n_errs++;
      $display("FAIL rmid_before: op=%0d addr=%h, expected 1 %h", bus.eng_op, bus.eng_addr, a);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.eng_op !== 3'd0 || bus.eng_addr !== 32'h0 || bus.cmd_err !== 1'b0 ||
        bus.done !== 1'b0 || bus.cmd_ready !== 1'b0 || perf_ops !== 32'h0) begin
      n_errs++;
      $display("FAIL rmid_async: op=%0d addr=%h err=%b done=%b ready=%b perf_ops=%0d, expected all 0",
               bus.eng_op, bus.eng_addr, bus.cmd_err, bus.done, bus.cmd_ready, perf_ops);
    end
    @(negedge clk);
    rst = 1'b0;
    auto_eng = 1'b1;
    @(negedge clk);
    send_cmd(7'd5, OPC, 32'h0, 32'h0, 1, "rmid_fence_empty", dc);
    repeat (4) @(negedge clk);
    n_checks++;
    if (m_starts != 0) begin
      n_errs++;
      $display("FAIL rmid_no_dispatch: %0d starts after reset, expected 0", m_starts);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_instr = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    rst           = 1'b1;
    test_reset();
    test_single();
    test_random();
    test_queue_fill();
    test_fence();
    test_illegal();
    test_perf();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/rocc_gemm_responder.md
Name: rocc_gemm_responder

Overview:
- Accelerator-side end of the core's GEMM custom-instruction handshake.
- The core side drives the command inputs and receives the done pulse. The responder accepts custom-0 commands with their rs1/rs2 operands and buffers them in an in-order queue.
- It dispatches queued commands to the GEMM engine one at a time over a start/done handshake.
- It returns a single-cycle done pulse that releases the core stall.

Parameters:
- QDEPTH, 4, command queue entries; power of two, ≥2.
- CUSTOM_OPC, 7'b0001011, opcode value treated as a GEMM command.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present; held by core until the cycle after done
- cmd_instr  in  32  command instruction word
- cmd_rs1  in  32  rs1 operand value
- cmd_rs2  in  32  rs2 operand value
- cmd_ready  out  1  responder can accept a command this cycle
- done  out  1  one-cycle pulse: current command retired from the core's view
- cmd_err  out  1  sticky: illegal funct7 or opcode seen
- eng_start  out  1  one-cycle pulse: engine begins op
- eng_op  out  3  op code, held from eng_start until eng_done
- eng_addr  out  32  rs1 of dispatched op, held the same way
- eng_arg  out  32  rs2 of dispatched op, held the same way
- eng_cfg_dim  out  32  config register (last CONFIG rs1)
- eng_cfg_stride  out  32  config register (last CONFIG rs2)
- eng_done  in  1  one-cycle pulse: engine finished current op
- perf_busy  out  32  engine-busy cycle count (see Optional Feature)
- perf_ops  out  32  dispatched-op count (see Optional Feature)

Behaviour:
- Reset (async, rst=1): every output is 0; queue is empty; FSM is IDLE; config registers are 0.
- Decode uses funct7 = cmd_instr[31:25]:
  - 0 CONFIG, 1 LOAD_A, 2 LOAD_B, 3 COMPUTE, 4 STORE_C: queued ops.
  - 5 FENCE: not queued.
  - Any other funct7, or cmd_instr[6:0]≠CUSTOM_OPC: illegal.
- Acceptance happens when cmd_valid & cmd_ready at an edge.
  - cmd_ready = !pending & !fence_wait & !full.
  - pending is set on acceptance and cleared in the cycle after the done pulse. This gives one ready-low gap so the held cmd_valid is never double-accepted.
- Queued op:
  - Pushed at the accept edge.
  - done = 1 exactly in the next cycle (latency 1).
- FENCE:
  - Sets fence_wait.
  - done pulses the cycle after the queue is empty and the FSM is in IDLE. Minimum latency is 1 when already idle.
- Illegal command:
  - Not queued.
  - Sets cmd_err (sticky until rst).
  - done pulses next cycle, so the core never hangs.
- Queue full: cmd_ready = 0; no push.
- Dispatch FSM (IDLE, ISSUE, WAIT_ENG):
  - IDLE, queue non-empty, head = CONFIG: pop; load eng_cfg_dim/eng_cfg_stride from rs1/rs2; stay IDLE. Takes one cycle and produces no eng_start.
  - IDLE, queue non-empty, head = other op: pop; latch op/rs1/rs2 into eng_* registers; go to ISSUE.
  - ISSUE: eng_start = 1 for one cycle; go to WAIT_ENG.
  - WAIT_ENG: hold eng_* outputs; on eng_done go to IDLE.
  - Result: at least 3 cycles per engine op.
  - eng_done in any state other than WAIT_ENG is ignored.
- Queue ordering:
  - Strict FIFO; CONFIG takes effect in order relative to engine ops.
  - Pointers are log2(QDEPTH)+1 bits; full/empty are derived from the MSB compare and wrap naturally.
  - Simultaneous push and pop when full: the pop frees a slot, but cmd_ready uses registered full, so the push is not accepted that cycle.
- Reset mid-operation: all state is dropped immediately. An in-flight engine op is abandoned; the engine is responsible for its own reset.

Optional Feature:
- Macro: GEMM_PERF_CNT_EN.
- Defined:
  - perf_busy increments every cycle the FSM is in ISSUE or WAIT_ENG.
  - perf_ops increments on every eng_start.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package gemm_pkg holds:
  - enum gemm_op_e: CONFIG=0, LOAD_A, LOAD_B, COMPUTE, STORE_C, FENCE=5.
  - Struct gemm_cmd_t {op 3b, rs1 32b, rs2 32b}.
  - GEMM_OPC constant.
- Sub-module gemm_cmd_fifo is natural: parameterised depth, gemm_cmd_t payload, push/pop/full/empty.

Test Plan:
- Reset: after rst=1, all outputs are 0 and cmd_ready=0. After release, cmd_ready=1 next cycle.
- Single op: LOAD_A with rs1=0x1000 and rs2=0x40, accepted at T0.
  - done=1 at T1; cmd_ready=0 at T1 and 1 at T2.
  - eng_start at T2 with eng_op=1, eng_addr=0x1000, eng_arg=0x40.
  - eng_done at T5 returns the FSM to IDLE.
- Queue fill: eng_done held 0; send CONFIG(0x00080008, 0x20), then LOAD_A, LOAD_B, COMPUTE, STORE_C.
  - CONFIG drains in one cycle and eng_cfg_dim=0x00080008.
  - LOAD_A is dispatched and held in WAIT_ENG.
  - Queue holds three ops; one more enqueue makes it full, and cmd_ready stays 0 until eng_done.
- FENCE: issued behind 2 queued ops; done does not pulse until the second eng_done, then pulses exactly 1 cycle after IDLE with an empty queue.
- Illegal: funct7=7 gives done at +1, cmd_err=1 (stays 1), and no eng_start.
- Reset mid-WAIT_ENG: assert rst asynchronously.
  - eng_op and eng_addr drop to 0 immediately.
  - Queue is empty afterwards.
  - perf_ops=0 (macro on).
